slow_rom_fetch_ctrl: RTL

- Sequencer and arbiter for the slow program-memory path: an 8-bit address feeds a long combinational settle chain, and data is valid only after a fixed number of clocks.
- Shares that path between the CPU instruction-fetch port and a debug read port using 2-way round-robin arbitration.
- Drives a registered address into the path, holds it for WAIT_CYCLES clocks, then captures the path output and pulses valid to the winning requester.
- Sits between the microprocessor fetch stage and the slow ROM wrapper.

---
 rtl/slow_rom_pkg.sv | 25 ++
 rtl/slow_rom_fetch_ctrl_rr_arb2.sv | 48 ++++
 rtl/slow_rom_fetch_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/slow_rom_pkg.sv
// ============================================================================
// Module   : slow_rom_pkg
// Brief    : Shared types for the slow program-memory fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package slow_rom_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } gnt_e;

  localparam int MIN_WAIT = 1;

endpackage

`default_nettype wire

// File: rtl/slow_rom_fetch_ctrl_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter with request mask; only last_grant
//            is registered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import slow_rom_pkg::*;
(
  input  logic       clk,
  input  logic       sync_reset_n,
  input  logic [1:0] req,         // bit 0 = CPU, bit 1 = debug
  input  logic [1:0] mask,        // set bits remove a requester from contention
  input  logic       update,      // the controller is taking the grant this cycle
  output logic [1:0] grant,
  output gnt_e       last_grant
);

  logic [1:0] w_req;
  gnt_e       r_last_grant;

  always_comb begin
    w_req = req & ~mask;
    grant = 2'b00;
    case (w_req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (r_last_grant == GNT_DBG) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to DBG so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_last_grant <= GNT_DBG;
    end else if (update && (grant != 2'b00)) begin
      r_last_grant <= grant[0] ? GNT_CPU : GNT_DBG;
    end
  end

  assign last_grant = r_last_grant;

endmodule

`default_nettype wire

// File: rtl/slow_rom_fetch_ctrl.sv
// ============================================================================
// Module   : slow_rom_fetch_ctrl
// Brief    : Sequences CPU / debug reads through a slow multi-cycle ROM path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slow_rom_fetch_ctrl
  import slow_rom_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              sync_reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  // An illegal zero wait is clamped to the shortest settle.
  localparam int c_wait = (WAIT_CYCLES < MIN_WAIT) ? MIN_WAIT : WAIT_CYCLES;
  localparam int CNT_W  = $clog2(c_wait + 1);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(c_wait - 1);

  state_e            r_state,     w_state_n;
  logic [CNT_W-1:0]  r_cnt,       w_cnt_n;
  logic [ADDR_W-1:0] r_rom_addr,  w_rom_addr_n;
  logic [DATA_W-1:0] r_cpu_data,  w_cpu_data_n;
  logic [DATA_W-1:0] r_dbg_data,  w_dbg_data_n;
  logic              r_cpu_valid, w_cpu_valid_n;
  logic              r_dbg_valid, w_dbg_valid_n;

  logic [1:0] w_grant;
  logic [1:0] w_mask;
  logic       w_update;
  gnt_e       w_last_grant;

  // last_grant always names the owner of the access in flight.
  always_comb begin
    w_mask = 2'b00;
    if (r_state == RESP) begin
      w_mask = (w_last_grant == GNT_CPU) ? 2'b01 : 2'b10;
    end
  end

  assign w_update = (r_state == IDLE) || (r_state == RESP);

  rr_arb2 u_arb (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .req          ({dbg_req, cpu_req}),
    .mask         (w_mask),
    .update       (w_update),
    .grant        (w_grant),
    .last_grant   (w_last_grant)
  );

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_rom_addr_n  = r_rom_addr;
    w_cpu_data_n  = r_cpu_data;
    w_dbg_data_n  = r_dbg_data;
    w_cpu_valid_n = 1'b0;
    w_dbg_valid_n = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_grant != 2'b00) begin
          w_rom_addr_n = w_grant[0] ? cpu_addr : dbg_addr;
          w_cnt_n      = c_cnt_load;
          w_state_n    = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end else begin
          if (w_last_grant == GNT_CPU) begin
            w_cpu_data_n  = rom_data;
            w_cpu_valid_n = 1'b1;
          end else begin
            w_dbg_data_n  = rom_data;
            w_dbg_valid_n = 1'b1;
          end
          w_state_n = RESP;
        end
      end
      RESP: begin
        // Hand the path straight to the other requester to skip IDLE.
        if (w_grant != 2'b00) begin
          w_rom_addr_n = w_grant[0] ? cpu_addr : dbg_addr;
          w_cnt_n      = c_cnt_load;
          w_state_n    = SETTLE;
        end else begin
          w_state_n = IDLE;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rom_addr  <= '0;
      r_cpu_data  <= '0;
      r_dbg_data  <= '0;
      r_cpu_valid <= 1'b0;
      r_dbg_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_rom_addr  <= w_rom_addr_n;
      r_cpu_data  <= w_cpu_data_n;
      r_dbg_data  <= w_dbg_data_n;
      r_cpu_valid <= w_cpu_valid_n;
      r_dbg_valid <= w_dbg_valid_n;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign cpu_data  = r_cpu_data;
  assign dbg_data  = r_dbg_data;
  assign cpu_valid = r_cpu_valid;
  assign dbg_valid = r_dbg_valid;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire
